// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared state encoding and default widths for the A/B feeder
package mm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } feed_state_e;

    localparam int MM_D_WIDTH    = 64;
    localparam int MM_ADDR_WIDTH = 16;
    localparam int MM_RD_DELAY   = 2;

endpackage

// File: rtl/feed_ab_if.sv
// rtl/feed_ab_if.sv - source-memory read ports and show-ahead A/B stream ports
interface feed_ab_if
    import mm_pkg::*;
#(
    parameter int D_WIDTH    = MM_D_WIDTH,
    parameter int ADDR_WIDTH = MM_ADDR_WIDTH
) ();

    logic                  mem_A_rd_en_out;
    logic [ADDR_WIDTH-1:0] mem_A_addr_out;
    logic [D_WIDTH-1:0]    mem_A_rdata_in;
    logic                  mem_B_rd_en_out;
    logic [ADDR_WIDTH-1:0] mem_B_addr_out;
    logic [D_WIDTH-1:0]    mem_B_rdata_in;

    logic [D_WIDTH-1:0]    data_A_FIFO_out;
    logic                  valid_A_FIFO_out;
    logic                  PASS_EN_A_FIFO_in;
    logic [D_WIDTH-1:0]    data_B_FIFO_out;
    logic                  valid_B_FIFO_out;
    logic                  PASS_EN_B_FIFO_in;

    modport master (
        output mem_A_rd_en_out, mem_A_addr_out,
        input  mem_A_rdata_in,
        output mem_B_rd_en_out, mem_B_addr_out,
        input  mem_B_rdata_in,
        output data_A_FIFO_out, valid_A_FIFO_out,
        input  PASS_EN_A_FIFO_in,
        output data_B_FIFO_out, valid_B_FIFO_out,
        input  PASS_EN_B_FIFO_in
    );

    modport slave (
        input  mem_A_rd_en_out, mem_A_addr_out,
        output mem_A_rdata_in,
        input  mem_B_rd_en_out, mem_B_addr_out,
        output mem_B_rdata_in,
        input  data_A_FIFO_out, valid_A_FIFO_out,
        output PASS_EN_A_FIFO_in,
        input  data_B_FIFO_out, valid_B_FIFO_out,
        output PASS_EN_B_FIFO_in
    );

endinterface

// File: rtl/feed_stream.sv
// rtl/feed_stream.sv - one stream: address sequencer, credit check, read-latency pipe, show-ahead FIFO
module feed_stream
    import mm_pkg::*;
#(
    parameter int D_WIDTH          = MM_D_WIDTH,
    parameter int ADDR_WIDTH       = MM_ADDR_WIDTH,
    parameter int NUM_WIDTH        = 1,
    parameter int TILE_WIDTH       = 8,
    parameter int RD_DELAY         = MM_RD_DELAY,
    parameter int FIFO_DEPTH_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_run,
    input  logic [ADDR_WIDTH-1:0] i_base,
    input  logic [TILE_WIDTH-1:0] i_tile_cnt,
    output logic                  o_mem_rd_en,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic [D_WIDTH-1:0]    i_mem_rdata,
    output logic [D_WIDTH-1:0]    o_fifo_data,
    output logic                  o_fifo_valid,
    input  logic                  i_pass_en,
    output logic                  o_issue_done,
    output logic                  o_pipe_empty
);

    localparam int CNT_W = TILE_WIDTH + NUM_WIDTH;
    localparam int DEPTH = 1 << FIFO_DEPTH_WIDTH;
    localparam int OCC_W = FIFO_DEPTH_WIDTH + 1;

    logic [ADDR_WIDTH-1:0]       r_addr;
    logic [CNT_W-1:0]            r_remaining;
    logic [RD_DELAY-1:0]         r_pipe;
    logic [OCC_W-1:0]            r_inflight;
    logic [OCC_W-1:0]            r_occ;
    logic [FIFO_DEPTH_WIDTH-1:0] r_wr_ptr;
    logic [FIFO_DEPTH_WIDTH-1:0] r_rd_ptr;
    logic [D_WIDTH-1:0]          r_mem [DEPTH];

    logic             w_rd_en;
    logic             w_arrive;
    logic             w_pop;
    logic             w_credit;
    logic [OCC_W:0]   w_used;

    // Words in flight are pre-reserved FIFO slots, so a full pipe can never overflow the FIFO.
    assign w_used   = {1'b0, r_occ} + {1'b0, r_inflight};
    assign w_credit = (w_used < (OCC_W + 1)'(DEPTH));
    assign w_rd_en  = i_run && (r_remaining != '0) && w_credit;
    assign w_arrive = r_pipe[RD_DELAY-1];
    assign w_pop    = i_pass_en && (r_occ != '0);

    assign o_mem_rd_en  = w_rd_en;
    assign o_mem_addr   = r_addr;
    assign o_fifo_valid = (r_occ != '0);
    assign o_fifo_data  = o_fifo_valid ? r_mem[r_rd_ptr] : '0;
    assign o_issue_done = (r_remaining == '0);
    assign o_pipe_empty = (r_inflight == '0);

    // Address and remaining-word counters; load on job accept, advance on each read strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_remaining <= '0;
        end else if (i_load) begin
            r_addr      <= i_base;
            r_remaining <= CNT_W'(i_tile_cnt) << NUM_WIDTH;
        end else if (w_rd_en) begin
            r_addr      <= r_addr + ADDR_WIDTH'(1);
            r_remaining <= r_remaining - CNT_W'(1);
        end
    end

    // Valid-bit pipe that tracks each read through the fixed memory latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= w_rd_en;
            for (int i = 1; i < RD_DELAY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    // Count of reads issued whose data has not yet landed in the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_rd_en, w_arrive})
                2'b10:   r_inflight <= r_inflight + OCC_W'(1);
                2'b01:   r_inflight <= r_inflight - OCC_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves occupancy unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_arrive) r_wr_ptr <= r_wr_ptr + FIFO_DEPTH_WIDTH'(1);
            if (w_pop)    r_rd_ptr <= r_rd_ptr + FIFO_DEPTH_WIDTH'(1);
            case ({w_arrive, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // FIFO storage; contents need no reset because the output is gated by occupancy.
    always_ff @(posedge clk) begin
        if (w_arrive) r_mem[r_wr_ptr] <= i_mem_rdata;
    end

endmodule

// File: rtl/feed_ab.sv
// rtl/feed_ab.sv - A/B FIFO-chain transmit feeder; optional stall counters under FEED_AB_STALL_CNT_EN
module feed_ab
    import mm_pkg::*;
#(
    parameter int D_WIDTH          = MM_D_WIDTH,
    parameter int ADDR_WIDTH       = MM_ADDR_WIDTH,
    parameter int A_NUM_WIDTH      = 1,
    parameter int B_NUM_WIDTH      = 1,
    parameter int TILE_WIDTH       = 8,
    parameter int RD_DELAY         = MM_RD_DELAY,
    parameter int FIFO_DEPTH_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_in,
    input  logic [ADDR_WIDTH-1:0] base_A_in,
    input  logic [ADDR_WIDTH-1:0] base_B_in,
    input  logic [TILE_WIDTH-1:0] tile_cnt_in,
    output logic                  busy_out,
    output logic                  done_out,
`ifdef FEED_AB_STALL_CNT_EN
    output logic [31:0]           stall_A_cnt_out,
    output logic [31:0]           stall_B_cnt_out,
`endif
    feed_ab_if.master             bus
);

    feed_state_e r_state;
    feed_state_e w_next_state;

    logic w_start_acc;
    logic w_run;
    logic w_active;
    logic w_a_valid, w_b_valid;
    logic w_a_issue_done, w_b_issue_done;
    logic w_a_pipe_empty, w_b_pipe_empty;
    logic w_all_issued;
    logic w_all_drained;

    assign w_all_issued  = w_a_issue_done && w_b_issue_done;
    assign w_all_drained = !w_a_valid && !w_b_valid && w_a_pipe_empty && w_b_pipe_empty;

    assign bus.valid_A_FIFO_out = w_a_valid;
    assign bus.valid_B_FIFO_out = w_b_valid;

    feed_stream #(
        .D_WIDTH          (D_WIDTH),
        .ADDR_WIDTH       (ADDR_WIDTH),
        .NUM_WIDTH        (A_NUM_WIDTH),
        .TILE_WIDTH       (TILE_WIDTH),
        .RD_DELAY         (RD_DELAY),
        .FIFO_DEPTH_WIDTH (FIFO_DEPTH_WIDTH)
    ) u_stream_a (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_start_acc),
        .i_run        (w_run),
        .i_base       (base_A_in),
        .i_tile_cnt   (tile_cnt_in),
        .o_mem_rd_en  (bus.mem_A_rd_en_out),
        .o_mem_addr   (bus.mem_A_addr_out),
        .i_mem_rdata  (bus.mem_A_rdata_in),
        .o_fifo_data  (bus.data_A_FIFO_out),
        .o_fifo_valid (w_a_valid),
        .i_pass_en    (bus.PASS_EN_A_FIFO_in),
        .o_issue_done (w_a_issue_done),
        .o_pipe_empty (w_a_pipe_empty)
    );

    feed_stream #(
        .D_WIDTH          (D_WIDTH),
        .ADDR_WIDTH       (ADDR_WIDTH),
        .NUM_WIDTH        (B_NUM_WIDTH),
        .TILE_WIDTH       (TILE_WIDTH),
        .RD_DELAY         (RD_DELAY),
        .FIFO_DEPTH_WIDTH (FIFO_DEPTH_WIDTH)
    ) u_stream_b (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_start_acc),
        .i_run        (w_run),
        .i_base       (base_B_in),
        .i_tile_cnt   (tile_cnt_in),
        .o_mem_rd_en  (bus.mem_B_rd_en_out),
        .o_mem_addr   (bus.mem_B_addr_out),
        .i_mem_rdata  (bus.mem_B_rdata_in),
        .o_fifo_data  (bus.data_B_FIFO_out),
        .o_fifo_valid (w_b_valid),
        .i_pass_en    (bus.PASS_EN_B_FIFO_in),
        .o_issue_done (w_b_issue_done),
        .o_pipe_empty (w_b_pipe_empty)
    );

    // Job state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // Next state and job-level strobes. An empty job skips DRAIN so done lands two cycles after start.
    always_comb begin
        w_next_state = r_state;
        w_start_acc  = 1'b0;
        w_run        = 1'b0;
        w_active     = 1'b0;
        busy_out     = 1'b0;
        done_out     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_in) begin
                    w_start_acc  = 1'b1;
                    w_next_state = RUN;
                end
            end
            RUN: begin
                w_run    = 1'b1;
                w_active = 1'b1;
                busy_out = 1'b1;
                if (w_all_issued) w_next_state = w_all_drained ? DONE : DRAIN;
            end
            DRAIN: begin
                w_active = 1'b1;
                busy_out = 1'b1;
                if (w_all_drained) w_next_state = DONE;
            end
            DONE: begin
                busy_out     = 1'b1;
                done_out     = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

`ifdef FEED_AB_STALL_CNT_EN
    logic [31:0] r_stall_a;
    logic [31:0] r_stall_b;
    logic        w_a_outstanding;
    logic        w_b_outstanding;

    assign w_a_outstanding = !w_a_issue_done || !w_a_pipe_empty;
    assign w_b_outstanding = !w_b_issue_done || !w_b_pipe_empty;
    assign stall_A_cnt_out = r_stall_a;
    assign stall_B_cnt_out = r_stall_b;

    // Saturating count of cycles the A head is starved while A words are still owed.
    always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
            r_stall_a <= '0;
        end else if (w_active && !w_a_valid && w_a_outstanding && (r_stall_a != '1)) begin
            r_stall_a <= r_stall_a + 32'd1;
        end
    end

    // Saturating count of cycles the B head is starved while B words are still owed.
    always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
            r_stall_b <= '0;
        end else if (w_active && !w_b_valid && w_b_outstanding && (r_stall_b != '1)) begin
            r_stall_b <= r_stall_b + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_feed_ab.sv
// tb/tb_feed_ab.sv - directed self-checking bench for feed_ab
module tb_feed_ab;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_in;
    logic [15:0] base_A_in;
    logic [15:0] base_B_in;
    logic [7:0]  tile_cnt_in;
    logic        busy_out;
    logic        done_out;
`ifdef FEED_AB_STALL_CNT_EN
    logic [31:0] stall_A_cnt_out;
    logic [31:0] stall_B_cnt_out;
`endif

    feed_ab_if #(.D_WIDTH(64), .ADDR_WIDTH(16)) bus ();

    feed_ab #(
        .D_WIDTH(64), .ADDR_WIDTH(16), .A_NUM_WIDTH(1), .B_NUM_WIDTH(1),
        .TILE_WIDTH(8), .RD_DELAY(2), .FIFO_DEPTH_WIDTH(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_in    (start_in),
        .base_A_in   (base_A_in),
        .base_B_in   (base_B_in),
        .tile_cnt_in (tile_cnt_in),
        .busy_out    (busy_out),
        .done_out    (done_out),
`ifdef FEED_AB_STALL_CNT_EN
        .stall_A_cnt_out (stall_A_cnt_out),
        .stall_B_cnt_out (stall_B_cnt_out),
`endif
        .bus         (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_a(input logic [15:0] a);
        return {16'hA0A0, a, ~a, 16'hCAFE};
    endfunction

    function automatic logic [63:0] mem_b(input logic [15:0] a);
        return {16'hB0B0, a, a ^ 16'h5A5A, 16'hBEEF};
    endfunction

    // Source memories with a fixed two-cycle read latency.
    logic [15:0] a_d1, a_d2, b_d1, b_d2;
    always @(posedge clk) begin
        a_d1 <= bus.mem_A_addr_out;
        a_d2 <= a_d1;
        b_d1 <= bus.mem_B_addr_out;
        b_d2 <= b_d1;
    end
    assign bus.mem_A_rdata_in = mem_a(a_d2);
    assign bus.mem_B_rdata_in = mem_b(b_d2);

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int pass_mode = 0;

    logic [15:0] exp_pop_a, exp_pop_b, exp_rd_a, exp_rd_b;
    logic [15:0] rd_a_log [2];
    int pops_a, pops_b, rds_a, rds_b;
    int done_cnt, done_cyc, busy_cnt, busy_first, last_b_pop;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_pass();
        case (pass_mode)
            1: begin
                bus.PASS_EN_A_FIFO_in = (cyc > 20);
                bus.PASS_EN_B_FIFO_in = (cyc > 20);
            end
            2: begin
                bus.PASS_EN_A_FIFO_in = 1'b1;
                bus.PASS_EN_B_FIFO_in = (cyc % 3 == 0);
            end
            default: begin
                bus.PASS_EN_A_FIFO_in = 1'b1;
                bus.PASS_EN_B_FIFO_in = 1'b1;
            end
        endcase
    endtask

    // Mid-cycle scoreboard: pop order, read-address sequence, done and busy timing.
    task automatic sample();
        if (bus.valid_A_FIFO_out && bus.PASS_EN_A_FIFO_in) begin
            check("pop_A", bus.data_A_FIFO_out, mem_a(exp_pop_a));
            exp_pop_a++;
            pops_a++;
        end
        if (bus.valid_B_FIFO_out && bus.PASS_EN_B_FIFO_in) begin
            check("pop_B", bus.data_B_FIFO_out, mem_b(exp_pop_b));
            exp_pop_b++;
            pops_b++;
            last_b_pop = cyc;
        end
        if (bus.mem_A_rd_en_out) begin
            check("rd_addr_A", bus.mem_A_addr_out, exp_rd_a);
            if (rds_a < 2) rd_a_log[rds_a] = bus.mem_A_addr_out;
            exp_rd_a++;
            rds_a++;
        end
        if (bus.mem_B_rd_en_out) begin
            check("rd_addr_B", bus.mem_B_addr_out, exp_rd_b);
            exp_rd_b++;
            rds_b++;
        end
        if (done_out) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy_out) begin
            if (busy_cnt == 0) busy_first = cyc;
            busy_cnt++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc++;
        drive_pass();
    endtask

    task automatic start_job(input logic [15:0] ba, input logic [15:0] bb,
                             input logic [7:0] tiles, input int mode);
        pass_mode   = mode;
        base_A_in   = ba;
        base_B_in   = bb;
        tile_cnt_in = tiles;
        exp_pop_a = ba; exp_pop_b = bb; exp_rd_a = ba; exp_rd_b = bb;
        pops_a = 0; pops_b = 0; rds_a = 0; rds_b = 0;
        done_cnt = 0; done_cyc = -1; busy_cnt = 0; busy_first = -1; last_b_pop = -1;
        cyc = 0;
        start_in = 1'b1;
        drive_pass();
        tick();
        start_in = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        while (done_cnt == 0 && cyc < bound) tick();
        check("done_seen", done_cnt, 1);
        repeat (3) tick();
        check("done_once", done_cnt, 1);
        check("idle_after_done", busy_out, 0);
    endtask

    initial begin
        rst = 1'b1;
        start_in = 1'b0;
        base_A_in = '0;
        base_B_in = '0;
        tile_cnt_in = '0;
        bus.PASS_EN_A_FIFO_in = 1'b0;
        bus.PASS_EN_B_FIFO_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy_out, 0);
        check("rst_done", done_out, 0);
        check("rst_rd_en_A", bus.mem_A_rd_en_out, 0);
        check("rst_addr_A", bus.mem_A_addr_out, 0);
        check("rst_valid_A", bus.valid_A_FIFO_out, 0);
        check("rst_valid_B", bus.valid_B_FIFO_out, 0);
        check("rst_data_A", bus.data_A_FIFO_out, 0);
        rst = 1'b0;
        repeat (2) tick();

        // Basic: one tile, consumer always ready.
        start_job(16'h0100, 16'h0200, 8'd1, 0);
        check("basic_rd_en_c1", bus.mem_A_rd_en_out, 1);
        check("basic_addr_c1", bus.mem_A_addr_out, 16'h0100);
        check("basic_busy_c1", busy_out, 1);
        tick();
        check("basic_addr_c2", bus.mem_A_addr_out, 16'h0101);
        tick();
        check("basic_valid_c3", bus.valid_A_FIFO_out, 0);
        tick();
        check("basic_valid_c4", bus.valid_A_FIFO_out, 1);
        check("basic_data_c4", bus.data_A_FIFO_out, mem_a(16'h0100));
        check("basic_validB_c4", bus.valid_B_FIFO_out, 1);
        wait_done(40);
        check("basic_done_cyc", done_cyc, 7);
        check("basic_pops_A", pops_a, 2);
        check("basic_pops_B", pops_b, 2);
        check("basic_rds_A", rds_a, 2);
`ifdef FEED_AB_STALL_CNT_EN
        check("basic_stall_A", stall_A_cnt_out, 3);
        check("basic_stall_B", stall_B_cnt_out, 3);
`endif

        // Backpressure: consumer stalled through cycle 20.
        start_job(16'h1000, 16'h2000, 8'd4, 1);
        while (cyc < 10) tick();
        check("bp_head_A_c10", bus.data_A_FIFO_out, mem_a(16'h1000));
        while (cyc < 20) tick();
        check("bp_rds_A", rds_a, 4);
        check("bp_rds_B", rds_b, 4);
        check("bp_valid_A_c20", bus.valid_A_FIFO_out, 1);
        check("bp_head_A_c20", bus.data_A_FIFO_out, mem_a(16'h1000));
        check("bp_head_B_c20", bus.data_B_FIFO_out, mem_b(16'h2000));
        check("bp_pops_held", pops_a, 0);
        wait_done(200);
        check("bp_pops_A", pops_a, 8);
        check("bp_pops_B", pops_b, 8);
        check("bp_rds_A_total", rds_a, 8);

        // Zero tiles.
        start_job(16'h4000, 16'h4000, 8'd0, 0);
        wait_done(20);
        check("zero_done_cyc", done_cyc, 2);
        check("zero_rds_A", rds_a, 0);
        check("zero_rds_B", rds_b, 0);
        check("zero_busy_first", busy_first, 1);
        check("zero_busy_cnt", busy_cnt, 2);

        // Skewed consumption, with a stray start while busy.
        start_job(16'h7000, 16'h8000, 8'd2, 2);
        while (cyc < 5) tick();
        start_in = 1'b1;
        base_A_in = 16'hDEAD;
        base_B_in = 16'hBEAD;
        tick();
        start_in = 1'b0;
        wait_done(200);
        check("skew_pops_A", pops_a, 4);
        check("skew_pops_B", pops_b, 4);
        check("skew_done_after_B", done_cyc, last_b_pop + 2);

        // Reset mid-job after three reads, then restart from a new base.
        start_job(16'h0300, 16'h0380, 8'd4, 0);
        while (cyc < 4) tick();
        check("rstjob_rds_A", rds_a, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstjob_valid_A", bus.valid_A_FIFO_out, 0);
        check("rstjob_valid_B", bus.valid_B_FIFO_out, 0);
        check("rstjob_busy", busy_out, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rstjob_late_valid_A", bus.valid_A_FIFO_out, 0);
            check("rstjob_late_data_A", bus.data_A_FIFO_out, 0);
        end
        start_job(16'h0500, 16'h0580, 8'd1, 0);
        while (cyc < 4) tick();
        check("rstjob_new_valid", bus.valid_A_FIFO_out, 1);
        check("rstjob_new_head_A", bus.data_A_FIFO_out, mem_a(16'h0500));
        check("rstjob_new_head_B", bus.data_B_FIFO_out, mem_b(16'h0580));
        wait_done(40);
        check("rstjob_new_pops_A", pops_a, 2);

        // Address wrap at the top of the A space.
        start_job(16'hFFFF, 16'h0010, 8'd1, 0);
        wait_done(40);
        check("wrap_addr0", rd_a_log[0], 16'hFFFF);
        check("wrap_addr1", rd_a_log[1], 16'h0000);
        check("wrap_pops_A", pops_a, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
